// File: rtl/uart_host_port.sv
// Host side of the UART: a TX FIFO drained into the UART through DIN/OE/RDY,
// and an RX FIFO filled from the UART's INT pulse, with a sticky overflow flag.

module uart_host_fifo #(
    parameter int Wdata  = 8,
    parameter int Depth  = 16,
    parameter int Wlevel = $clog2(Depth) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr,
    input  logic [Wdata-1:0]  din,
    input  logic              rd,
    output logic [Wdata-1:0]  head,
    output logic [Wlevel-1:0] level
);
    localparam int Wptr = $clog2(Depth);

    logic [Wdata-1:0] mem [Depth];
    logic [Wptr-1:0]  wptr, rptr;

    // wr/rd arrive already qualified against full/empty by the owner.
    always_ff @(posedge CLK)
        if (wr) mem[wptr] <= din;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            case ({wr, rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head = mem[rptr];
endmodule

module uart_host_port #(
    parameter int Wdata  = 8,
    parameter int Depth  = 16,
    parameter int Wlevel = $clog2(Depth) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [Wdata-1:0]  TX_DIN,
    input  logic              TX_WE,
    output logic              TX_FULL,
    output logic [Wlevel-1:0] TX_LEVEL,
    output logic [Wdata-1:0]  RX_DOUT,
    input  logic              RX_RE,
    output logic              RX_EMPTY,
    output logic [Wlevel-1:0] RX_LEVEL,
    output logic              OVR,
    input  logic              OVR_CLR,
    output logic [Wdata-1:0]  U_DIN,
    output logic              U_OE,
    input  logic              U_RDY,
    input  logic [Wdata-1:0]  U_DOUT,
    input  logic              U_INT
);
    typedef enum logic [1:0] {IDLE, ISSUE, GUARD} state_t;

    state_t           state, state_nxt;
    logic [Wdata-1:0] tx_head, rx_head;
    logic             tx_empty, rx_full;
    logic             tx_push, tx_pop, issue_ok;
    logic             rx_push, rx_pop, rx_drop;

    assign TX_FULL  = (TX_LEVEL == Wlevel'(Depth));
    assign tx_empty = (TX_LEVEL == '0);
    assign RX_EMPTY = (RX_LEVEL == '0);
    assign rx_full  = (RX_LEVEL == Wlevel'(Depth));

    // A full TX FIFO rejects the push even if the drain frees a slot this cycle.
    assign tx_push  = TX_WE && !TX_FULL;
    assign issue_ok = !tx_empty && U_RDY;

    assign rx_pop  = RX_RE && !RX_EMPTY;
    assign rx_drop = U_INT && rx_full && !RX_RE;
    assign rx_push = U_INT && !rx_drop;

    uart_host_fifo #(.Wdata(Wdata), .Depth(Depth), .Wlevel(Wlevel)) u_txf (
        .CLK(CLK), .RST(RST), .wr(tx_push), .din(TX_DIN), .rd(tx_pop),
        .head(tx_head), .level(TX_LEVEL)
    );

    uart_host_fifo #(.Wdata(Wdata), .Depth(Depth), .Wlevel(Wlevel)) u_rxf (
        .CLK(CLK), .RST(RST), .wr(rx_push), .din(U_DOUT), .rd(rx_pop),
        .head(rx_head), .level(RX_LEVEL)
    );

    assign RX_DOUT = RX_EMPTY ? '0 : rx_head;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // GUARD masks the cycle where the UART's RDY has not yet fallen after OE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue_ok) state_nxt = ISSUE;
            ISSUE:   state_nxt = GUARD;
            GUARD:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        U_OE   = (state == ISSUE);
        tx_pop = (state == IDLE) && issue_ok;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         U_DIN <= '0;
        else if (tx_pop) U_DIN <= tx_head;
    end

    // Set wins over clear when both land in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          OVR <= 1'b0;
        else if (rx_drop) OVR <= 1'b1;
        else if (OVR_CLR) OVR <= 1'b0;
    end
endmodule

// File: tb/tb_uart_host_port.sv
// Directed bench for uart_host_port: vector table for the RX path plus
// hand sequences for TX issue, overflow, mid-issue reset and a random stream.

module tb_uart_host_port;
    logic       CLK, RST;
    logic [7:0] TX_DIN, RX_DOUT, U_DIN, U_DOUT;
    logic       TX_WE, TX_FULL, RX_RE, RX_EMPTY, OVR, OVR_CLR, U_OE, U_RDY, U_INT;
    logic [4:0] TX_LEVEL, RX_LEVEL;

    int total = 0;
    int bad   = 0;

    uart_host_port dut (
        .CLK(CLK), .RST(RST), .TX_DIN(TX_DIN), .TX_WE(TX_WE), .TX_FULL(TX_FULL),
        .TX_LEVEL(TX_LEVEL), .RX_DOUT(RX_DOUT), .RX_RE(RX_RE), .RX_EMPTY(RX_EMPTY),
        .RX_LEVEL(RX_LEVEL), .OVR(OVR), .OVR_CLR(OVR_CLR), .U_DIN(U_DIN), .U_OE(U_OE),
        .U_RDY(U_RDY), .U_DOUT(U_DOUT), .U_INT(U_INT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        TX_DIN = '0; TX_WE = 0; RX_RE = 0; OVR_CLR = 0; U_RDY = 1; U_DOUT = '0; U_INT = 0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    typedef struct {
        logic       intr;
        logic [7:0] dout;
        logic       re;
        logic       clr;
        logic [4:0] lvl;
        logic [7:0] head;
        logic       empty;
        logic       ovr;
    } rxvec_t;

    rxvec_t vt[8];

    initial begin
        int n, last, busy, cyc, oe_cnt;
        logic [7:0] txq[$];
        logic [7:0] rxq[$];
        int tx_sent, tx_got, rx_sent, rx_got, tx_lvl, last_oe;
        logic tx_acc, rx_pop_m, rx_acc, rdy_prev;

        //            int  dout   re  clr lvl head  empty ovr
        vt[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd1, 8'h11, 1'b0, 1'b0};
        vt[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 5'd2, 8'h11, 1'b0, 1'b0};
        vt[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 5'd3, 8'h11, 1'b0, 1'b0};
        vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 8'h22, 1'b0, 1'b0};
        vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 8'h33, 1'b0, 1'b0};
        vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0};
        vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0};
        vt[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h00, 1'b1, 1'b0};

        // Reset values, sampled while RST is held.
        RST = 1'b1;
        TX_DIN = '0; TX_WE = 0; RX_RE = 0; OVR_CLR = 0; U_RDY = 1; U_DOUT = '0; U_INT = 0;
        tick();
        chk("rst_oe", U_OE, 0);
        chk("rst_din", U_DIN, 0);
        chk("rst_txfull", TX_FULL, 0);
        chk("rst_txlvl", TX_LEVEL, 0);
        chk("rst_rxempty", RX_EMPTY, 1);
        chk("rst_rxlvl", RX_LEVEL, 0);
        chk("rst_rxdout", RX_DOUT, 0);
        chk("rst_ovr", OVR, 0);
        tick();
        RST = 1'b0;

        // Single byte: WE in cycle c gives OE in cycle c+2.
        TX_DIN = 8'hA5; TX_WE = 1;
        tick();
        TX_WE = 0;
        chk("t1_lvl_c1", TX_LEVEL, 1);
        chk("t1_oe_c1", U_OE, 0);
        tick();
        chk("t1_oe_c2", U_OE, 1);
        chk("t1_din", U_DIN, 8'hA5);
        chk("t1_lvl_c2", TX_LEVEL, 0);
        tick();
        chk("t1_oe_c3", U_OE, 0);
        chk("t1_din_hold", U_DIN, 8'hA5);

        // Fill TX with RDY low, push while full, then drain with a UART model.
        do_reset();
        U_RDY = 0;
        for (int i = 1; i <= 16; i++) begin
            TX_DIN = 8'(i); TX_WE = 1;
            tick();
        end
        TX_WE = 0;
        chk("t2_full", TX_FULL, 1);
        chk("t2_lvl16", TX_LEVEL, 16);
        TX_DIN = 8'hFF; TX_WE = 1;
        tick();
        TX_WE = 0;
        chk("t2_lvl_ign", TX_LEVEL, 16);
        U_RDY = 1; n = 0; last = -100; busy = 0; cyc = 0;
        while (n < 16 && cyc < 400) begin
            tick();
            cyc++;
            if (U_OE) begin
                chk("t2_byte", U_DIN, n + 1);
                chk("t2_gap", (cyc - last) >= 3, 1);
                last = cyc; n++; busy = 10;
            end else if (busy > 0) busy--;
            U_RDY = (busy == 0);
        end
        chk("t2_count", n, 16);
        tick();
        chk("t2_lvl_end", TX_LEVEL, 0);
        chk("t2_nofull", TX_FULL, 0);

        // RX basic path from the vector table.
        do_reset();
        foreach (vt[i]) begin
            U_INT = vt[i].intr; U_DOUT = vt[i].dout; RX_RE = vt[i].re; OVR_CLR = vt[i].clr;
            tick();
            chk($sformatf("rxv%0d_lvl", i), RX_LEVEL, vt[i].lvl);
            chk($sformatf("rxv%0d_dout", i), RX_DOUT, vt[i].head);
            chk($sformatf("rxv%0d_empty", i), RX_EMPTY, vt[i].empty);
            chk($sformatf("rxv%0d_ovr", i), OVR, vt[i].ovr);
        end
        U_INT = 0; RX_RE = 0; OVR_CLR = 0;

        // RX overflow, full push+pop, clear, and set-beats-clear.
        for (int i = 0; i < 16; i++) begin
            U_INT = 1; U_DOUT = 8'(8'h80 + i);
            tick();
        end
        U_INT = 0;
        chk("ov_lvl16", RX_LEVEL, 16);
        chk("ov_head", RX_DOUT, 8'h80);
        U_INT = 1; U_DOUT = 8'h77;
        tick();
        U_INT = 0;
        chk("ov_set", OVR, 1);
        chk("ov_lvl", RX_LEVEL, 16);
        U_INT = 1; U_DOUT = 8'h99; RX_RE = 1;
        tick();
        U_INT = 0; RX_RE = 0;
        chk("ov_pp_lvl", RX_LEVEL, 16);
        chk("ov_pp_ovr", OVR, 1);
        chk("ov_pp_head", RX_DOUT, 8'h81);
        OVR_CLR = 1;
        tick();
        chk("ov_clr", OVR, 0);
        U_INT = 1; U_DOUT = 8'hAA;
        tick();
        U_INT = 0; OVR_CLR = 0;
        chk("ov_setwins", OVR, 1);
        chk("ov_lvl2", RX_LEVEL, 16);
        for (int i = 0; i < 16; i++) begin
            chk("ov_drain", RX_DOUT, (i < 15) ? 8'(8'h81 + i) : 8'h99);
            RX_RE = 1;
            tick();
        end
        RX_RE = 0;
        chk("ov_empty", RX_EMPTY, 1);
        chk("ov_dout0", RX_DOUT, 0);

        // Reset asserted while in ISSUE with bytes queued.
        do_reset();
        U_RDY = 0;
        for (int i = 0; i < 5; i++) begin
            TX_DIN = 8'(8'hC0 + i); TX_WE = 1;
            tick();
        end
        TX_WE = 0; U_RDY = 1;
        tick();
        chk("mr_issue", U_OE, 1);
        chk("mr_lvl4", TX_LEVEL, 4);
        RST = 1;
        #1;
        chk("mr_oe_drop", U_OE, 0);
        chk("mr_lvl0", TX_LEVEL, 0);
        tick();
        RST = 0;
        oe_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (U_OE) oe_cnt++;
        end
        chk("mr_no_oe", oe_cnt, 0);

        // Random stream of 40 bytes through each FIFO against a scoreboard.
        do_reset();
        tx_sent = 0; tx_got = 0; rx_sent = 0; rx_got = 0; tx_lvl = 0; last_oe = -100; cyc = 0;
        while ((tx_got < 40 || rx_got < 40) && cyc < 3000) begin
            TX_WE  = (tx_sent < 40) && ($urandom_range(0, 1) == 1);
            TX_DIN = 8'(8'h30 + tx_sent);
            U_RDY  = ($urandom_range(0, 2) != 0);
            RX_RE  = ($urandom_range(0, 1) == 1);
            U_INT  = (rx_sent < 40) && ($urandom_range(0, 1) == 1) && (rxq.size() < 16 || RX_RE);
            U_DOUT = 8'(8'h50 + rx_sent);
            tx_acc   = TX_WE && (tx_lvl < 16);
            rx_pop_m = RX_RE && (rxq.size() > 0);
            rx_acc   = U_INT && (rxq.size() < 16 || rx_pop_m);
            rdy_prev = U_RDY;
            tick();
            cyc++;
            if (tx_acc) begin
                txq.push_back(TX_DIN);
                tx_sent++; tx_lvl++;
            end
            if (U_OE) begin
                chk("rs_tx_order", U_DIN, txq.pop_front());
                chk("rs_tx_rdy", rdy_prev, 1);
                chk("rs_tx_gap", (cyc - last_oe) >= 3, 1);
                last_oe = cyc; tx_got++; tx_lvl--;
            end
            chk("rs_tx_lvl", TX_LEVEL, tx_lvl);
            if (rx_pop_m) begin
                void'(rxq.pop_front());
                rx_got++;
            end
            if (rx_acc) begin
                rxq.push_back(U_DOUT);
                rx_sent++;
            end
            chk("rs_rx_lvl", RX_LEVEL, rxq.size());
            chk("rs_rx_dout", RX_DOUT, (rxq.size() > 0) ? rxq[0] : 8'h00);
            chk("rs_ovr", OVR, 0);
        end
        chk("rs_done", tx_got + rx_got, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
